// File: rtl/mem_stage.sv
// LC-3b memory stage: EX/MEM pipeline register plus a three-state data-memory FSM.
// Handles word/byte loads and stores, and the two-access indirect LDI/STI.
package lc3b_types;
  typedef enum logic [3:0] {
    op_br   = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb  = 4'b0011,
    op_jsr  = 4'b0100, op_and = 4'b0101, op_ldr = 4'b0110, op_str  = 4'b0111,
    op_rti  = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti  = 4'b1011,
    op_jmp  = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       mem_read;
    logic       mem_write;
    logic       load_cc;
    logic       load_regfile;
    logic       branch_stall;
  } lc3b_control_word;
endpackage

module mem_stage
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_mem,
  input  logic             ex_valid,
  input  lc3b_control_word ex_cw,
  input  logic [ADDR_W-1:0] ex_address,
  input  logic [ADDR_W-1:0] ex_result,
  input  logic [ADDR_W-1:0] ex_npc,
  input  logic [ADDR_W-1:0] ex_ir,
  input  lc3b_reg          ex_dr,
  output logic [ADDR_W-1:0] dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [ADDR_W-1:0] dmem_wdata,
  output logic [1:0]       dmem_wmask,
  input  logic [ADDR_W-1:0] dmem_rdata,
  input  logic             dmem_resp,
  output logic             wb_valid,
  output lc3b_control_word wb_cw,
  output logic [ADDR_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_npc,
  output logic [ADDR_W-1:0] wb_ir,
  output lc3b_reg          wb_dr,
  output logic             wb_load_cc,
  output logic             wb_load_regfile,
  output logic             mem_stall,
  output logic             mem_br_stall
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

  state_t           state, next_state;
  logic             valid_q;
  lc3b_control_word cw_q;
  logic [ADDR_W-1:0] address_q, result_q, npc_q, ir_q, ptr_q, data_q;
  lc3b_reg          dr_q;

  logic is_ldr, is_ldb, is_ldi, is_str, is_stb, is_sti;
  logic indirect, is_load, capture, load_done;
  logic [7:0]        load_byte;
  logic [ADDR_W-1:0] load_data;

  assign is_ldr   = (cw_q.opcode == op_ldr);
  assign is_ldb   = (cw_q.opcode == op_ldb);
  assign is_ldi   = (cw_q.opcode == op_ldi);
  assign is_str   = (cw_q.opcode == op_str);
  assign is_stb   = (cw_q.opcode == op_stb);
  assign is_sti   = (cw_q.opcode == op_sti);
  assign indirect = is_ldi | is_sti;
  assign is_load  = is_ldr | is_ldb | is_ldi;

  // Byte lane follows the unaligned effective address; the bus itself is word-aligned.
  assign load_byte = address_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
  assign load_data = is_ldb ? {{(ADDR_W-8){load_byte[7]}}, load_byte} : dmem_rdata;
  assign load_done = dmem_resp &&
                     (((state == ACC1) && (is_ldr || is_ldb)) || ((state == ACC2) && is_ldi));

  always_comb begin
    next_state   = state;
    mem_stall    = 1'b0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = '0;
    dmem_wdata   = '0;
    dmem_wmask   = 2'b00;
    capture      = 1'b0;
    case (state)
      ACC1: begin
        dmem_address = {address_q[ADDR_W-1:1], 1'b0};
        dmem_read    = is_ldr | is_ldb | is_ldi | is_sti;
        dmem_write   = is_str | is_stb;
        if (is_stb) begin
          dmem_wdata = {(ADDR_W/8){result_q[7:0]}};
          dmem_wmask = address_q[0] ? 2'b10 : 2'b01;
        end else if (is_str) begin
          dmem_wdata = result_q;
          dmem_wmask = 2'b11;
        end
        mem_stall = !(dmem_resp && !indirect);
        if (dmem_resp) next_state = indirect ? ACC2 : IDLE;
      end
      ACC2: begin
        dmem_address = {ptr_q[ADDR_W-1:1], 1'b0};
        dmem_read    = is_ldi;
        dmem_write   = is_sti;
        if (is_sti) begin
          dmem_wdata = result_q;
          dmem_wmask = 2'b11;
        end
        mem_stall = !dmem_resp;
        if (dmem_resp) next_state = IDLE;
      end
      default: ;
    endcase
    // A capture on the completing cycle starts the next instruction directly.
    capture = load_mem && !mem_stall;
    if (capture)
      next_state = (ex_valid && (ex_cw.mem_read || ex_cw.mem_write)) ? ACC1 : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      cw_q      <= '0;
      address_q <= '0;
      result_q  <= '0;
      npc_q     <= '0;
      ir_q      <= '0;
      dr_q      <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        valid_q   <= ex_valid;
        cw_q      <= ex_cw;
        address_q <= ex_address;
        result_q  <= ex_result;
        npc_q     <= ex_npc;
        ir_q      <= ex_ir;
        dr_q      <= ex_dr;
      end
      if ((state == ACC1) && dmem_resp && indirect) ptr_q <= dmem_rdata;
      if (load_done) data_q <= load_data;
    end
  end

  // Forward the load result on the completion cycle so writeback sees it immediately.
  assign wb_data         = is_load ? (load_done ? load_data : data_q) : result_q;
  assign wb_valid        = valid_q && !mem_stall;
  assign wb_cw           = cw_q;
  assign wb_npc          = npc_q;
  assign wb_ir           = ir_q;
  assign wb_dr           = dr_q;
  assign wb_load_cc      = valid_q & cw_q.load_cc;
  assign wb_load_regfile = valid_q & cw_q.load_regfile;
  assign mem_br_stall    = valid_q & cw_q.branch_stall;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected memory accesses and writeback records are
// queued at issue time and checked by a combined memory-model / monitor process.
module tb_mem_stage;
  import lc3b_types::*;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic [15:0] rdata;
    int          waits;
  } acc_t;

  typedef struct {
    logic [15:0] data;
    logic [15:0] npc;
    logic [15:0] ir;
    logic [2:0]  dr;
    logic        lr;
    int          stalls;
  } wb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_mem = 1'b0;
  logic ex_valid = 1'b0;
  lc3b_control_word ex_cw = '0;
  logic [15:0] ex_address = '0, ex_result = '0, ex_npc = '0, ex_ir = '0;
  lc3b_reg ex_dr = '0;
  logic [15:0] dmem_address, dmem_wdata, wb_data, wb_npc, wb_ir;
  logic [15:0] dmem_rdata = '0;
  logic dmem_read, dmem_write, dmem_resp = 1'b0;
  logic [1:0] dmem_wmask;
  logic wb_valid, wb_load_cc, wb_load_regfile, mem_stall, mem_br_stall;
  lc3b_control_word wb_cw;
  lc3b_reg wb_dr;

  int checks = 0;
  int errors = 0;
  acc_t acc_q[$];
  wb_t  wb_q[$];
  logic late_resp_go = 1'b0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .load_mem(load_mem), .ex_valid(ex_valid), .ex_cw(ex_cw),
    .ex_address(ex_address), .ex_result(ex_result), .ex_npc(ex_npc), .ex_ir(ex_ir),
    .ex_dr(ex_dr), .dmem_address(dmem_address), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .wb_valid(wb_valid), .wb_cw(wb_cw),
    .wb_data(wb_data), .wb_npc(wb_npc), .wb_ir(wb_ir), .wb_dr(wb_dr),
    .wb_load_cc(wb_load_cc), .wb_load_regfile(wb_load_regfile), .mem_stall(mem_stall),
    .mem_br_stall(mem_br_stall)
  );

  // Memory model (posedge+2) and writeback monitor (negedge) share one process.
  int   cnt = 0;
  logic busy = 1'b0;
  logic late_done = 1'b0;
  logic consumed = 1'b1;
  int   stall_cnt = 0;
  acc_t a;
  wb_t  e;
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (load_mem && !mem_stall && !reset) begin
        consumed  = 1'b0;
        stall_cnt = 0;
      end
      #2;
      dmem_resp = 1'b0;
      if (reset) begin
        if (busy) void'(acc_q.pop_front());
        busy = 1'b0;
        cnt  = 0;
      end else if (late_resp_go && !late_done) begin
        dmem_resp = 1'b1;
        late_done = 1'b1;
      end else if (dmem_read || dmem_write) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: addr=%h rd=%b wr=%b, required no access",
                   dmem_address, dmem_read, dmem_write);
        end else begin
          a    = acc_q[0];
          busy = 1'b1;
          if (cnt == a.waits) begin
            checks++;
            if ((dmem_write !== a.wr) || (dmem_read !== !a.wr) || (dmem_address !== a.addr) ||
                (a.wr && ((dmem_wdata !== a.wdata) || (dmem_wmask !== a.wmask)))) begin
              errors++;
              $display("FAIL access: got rd=%b wr=%b addr=%h wdata=%h wmask=%b, required wr=%b addr=%h wdata=%h wmask=%b",
                       dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask,
                       a.wr, a.addr, a.wdata, a.wmask);
            end
            $display("ACCESS %s addr=%h wdata=%h wmask=%b rdata=%h",
                     a.wr ? "WR" : "RD", dmem_address, dmem_wdata, dmem_wmask, a.rdata);
            dmem_rdata = a.rdata;
            dmem_resp  = 1'b1;
            void'(acc_q.pop_front());
            busy = 1'b0;
            cnt  = 0;
          end else begin
            cnt++;
          end
        end
      end
    end else begin
      if (mem_stall) stall_cnt++;
      if (wb_valid && !consumed) begin
        consumed = 1'b1;
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wb: wb_ir=%h, required no writeback", wb_ir);
        end else begin
          e = wb_q.pop_front();
          if (wb_data !== e.data) begin
            errors++;
            $display("FAIL wb_data: got %h, required %h", wb_data, e.data);
          end
          checks++;
          if ({wb_npc, wb_ir, wb_dr, wb_load_regfile} !== {e.npc, e.ir, e.dr, e.lr}) begin
            errors++;
            $display("FAIL wb_meta: got npc=%h ir=%h dr=%0d lr=%b, required npc=%h ir=%h dr=%0d lr=%b",
                     wb_npc, wb_ir, wb_dr, wb_load_regfile, e.npc, e.ir, e.dr, e.lr);
          end
          checks++;
          if (stall_cnt != e.stalls) begin
            errors++;
            $display("FAIL stall_cycles: got %0d, required %0d", stall_cnt, e.stalls);
          end
          $display("WB ir=%h data=%h stalls=%0d", wb_ir, wb_data, stall_cnt);
        end
      end
    end
  end

  task automatic acc(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [1:0] wmask, input logic [15:0] rdata, input int waits);
    acc_t r;
    r.wr = wr; r.addr = addr; r.wdata = wdata; r.wmask = wmask; r.rdata = rdata; r.waits = waits;
    acc_q.push_back(r);
  endtask

  task automatic send(input lc3b_opcode op, input logic valid, input logic [15:0] addr,
                      input logic [15:0] result, input logic [15:0] npc,
                      input logic [15:0] exp_data, input int exp_stalls);
    int b;
    wb_t w;
    logic ld, st;
    ld = (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
    st = (op == op_str) || (op == op_stb) || (op == op_sti);
    b = 0;
    @(negedge clk); #1;
    while (mem_stall && b < 200) begin
      @(negedge clk); #1;
      b++;
    end
    if (mem_stall) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: mem_stall=%b after %0d cycles, required 0", mem_stall, b);
    end
    ex_valid             = valid;
    ex_cw                = '0;
    ex_cw.opcode         = op;
    ex_cw.mem_read       = ld || (op == op_sti);
    ex_cw.mem_write      = st;
    ex_cw.load_cc        = ld || (op == op_add);
    ex_cw.load_regfile   = ld || (op == op_add);
    ex_address           = addr;
    ex_result            = result;
    ex_npc               = npc;
    ex_ir                = {op, addr[11:0]};
    ex_dr                = npc[3:1];
    load_mem             = 1'b1;
    if (valid) begin
      w.data = exp_data; w.npc = npc; w.ir = {op, addr[11:0]}; w.dr = npc[3:1];
      w.lr = ld || (op == op_add); w.stalls = exp_stalls;
      wb_q.push_back(w);
    end
    @(posedge clk); #1;
    load_mem = 1'b0;
    ex_valid = 1'b0;
  endtask

  task automatic quiet(input string name);
    checks++;
    if (dmem_read || dmem_write || mem_stall || wb_valid) begin
      errors++;
      $display("FAIL %s: got rd=%b wr=%b stall=%b wb_valid=%b, required all 0",
               name, dmem_read, dmem_write, mem_stall, wb_valid);
    end
  endtask

  initial begin
    int b;
    #1;
    checks++;
    if ({dmem_read, dmem_write, mem_stall, wb_valid, dmem_address, wb_data, dmem_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rd=%b wr=%b stall=%b wb_valid=%b addr=%h data=%h wmask=%b, required all 0",
               dmem_read, dmem_write, mem_stall, wb_valid, dmem_address, wb_data, dmem_wmask);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    acc(1'b0, 16'h3000, 16'h0000, 2'b00, 16'hBEEF, 3);
    send(op_ldr, 1'b1, 16'h3000, 16'h0000, 16'h0102, 16'hBEEF, 3);
    acc(1'b0, 16'h3000, 16'h0000, 2'b00, 16'h4000, 0);
    acc(1'b0, 16'h4000, 16'h0000, 2'b00, 16'h1234, 1);
    send(op_ldi, 1'b1, 16'h3000, 16'h0000, 16'h0104, 16'h1234, 2);
    acc(1'b1, 16'h3000, 16'hABAB, 2'b10, 16'h0000, 0);
    send(op_stb, 1'b1, 16'h3001, 16'h00AB, 16'h0106, 16'h00AB, 0);
    acc(1'b0, 16'h3000, 16'h0000, 2'b00, 16'h80FF, 2);
    send(op_ldb, 1'b1, 16'h3001, 16'h0000, 16'h0108, 16'hFF80, 2);
    acc(1'b0, 16'h3002, 16'h0000, 2'b00, 16'h127F, 0);
    send(op_ldb, 1'b1, 16'h3002, 16'h0000, 16'h010A, 16'h007F, 0);
    acc(1'b1, 16'h2000, 16'h5A5A, 2'b11, 16'h0000, 1);
    send(op_str, 1'b1, 16'h2001, 16'h5A5A, 16'h010C, 16'h5A5A, 1);
    acc(1'b0, 16'h3100, 16'h0000, 2'b00, 16'h4101, 0);
    acc(1'b1, 16'h4100, 16'hCAFE, 2'b11, 16'h0000, 0);
    send(op_sti, 1'b1, 16'h3100, 16'hCAFE, 16'h010E, 16'hCAFE, 1);
    send(op_add, 1'b1, 16'h0000, 16'h1111, 16'h0110, 16'h1111, 0);
    acc(1'b1, 16'h3004, 16'hCDCD, 2'b01, 16'h0000, 0);
    send(op_stb, 1'b1, 16'h3004, 16'h12CD, 16'h0112, 16'h12CD, 0);

    // Bubble carrying a memory control word.
    send(op_ldr, 1'b0, 16'h3000, 16'h0000, 16'h0114, 16'h0000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      quiet("bubble");
    end

    // Reset in the middle of the STI write access.
    acc(1'b0, 16'h3200, 16'h0000, 2'b00, 16'h4200, 0);
    acc(1'b1, 16'h4200, 16'h7777, 2'b11, 16'h0000, 5);
    send(op_sti, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    wb_q.delete();
    ex_cw.opcode = op_sti;
    b = 0;
    // The bubble above only drains the pipe; issue the real STI now.
    void'(wb_q.size());
    @(negedge clk); #1;
    ex_valid = 1'b1; ex_cw.mem_read = 1'b1; ex_cw.mem_write = 1'b1;
    ex_address = 16'h3200; ex_result = 16'h7777; ex_npc = 16'h0116; ex_ir = 16'hB200;
    load_mem = 1'b1;
    @(posedge clk); #1;
    load_mem = 1'b0; ex_valid = 1'b0;
    while (!dmem_write && b < 20) begin
      @(negedge clk); #1;
      b++;
    end
    checks++;
    if (!dmem_write) begin
      errors++;
      $display("FAIL sti_acc2_reached: dmem_write=%b, required 1", dmem_write);
    end
    #2 reset = 1'b1;
    #1;
    quiet("async_reset_abort");
    checks++;
    if (dmem_address !== 16'h0000) begin
      errors++;
      $display("FAIL reset_address: got %h, required 0000", dmem_address);
    end
    @(negedge clk); #1;
    reset = 1'b0;
    late_resp_go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      quiet("late_resp_ignored");
    end

    acc(1'b0, 16'h5000, 16'h0000, 2'b00, 16'hA5A5, 0);
    send(op_ldr, 1'b1, 16'h5000, 16'h0000, 16'h0118, 16'hA5A5, 0);

    b = 0;
    while ((wb_q.size() != 0 || acc_q.size() != 0) && b < 300) begin
      @(negedge clk);
      b++;
    end
    #1;
    checks++;
    if (wb_q.size() != 0 || acc_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending wb=%0d acc=%0d, required 0 and 0", wb_q.size(), acc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
